// File: rtl/sos_coef_loader_if.sv
// Coefficient configuration stream between a host-side writer and the loader.
//
// Handshake: a word moves on a rising clock edge when cfg_valid and
// cfg_ready are both 1. The writer holds cfg_data stable while cfg_valid is
// high and the word has not moved yet. The loader may raise or drop
// cfg_ready in any cycle, and cfg_ready may depend combinationally on the
// loader's state.
//
// Signals:
//   cfg_data  [W-1:0]  signed coefficient word (writer -> loader)
//   cfg_valid          cfg_data is valid         (writer -> loader)
//   cfg_ready          loader takes a word now   (loader -> writer)
interface sos_coef_loader_if #(
  parameter int W = 16
);
  logic [W-1:0] cfg_data;
  logic         cfg_valid;
  logic         cfg_ready;

  modport master (
    output cfg_data,
    output cfg_valid,
    input  cfg_ready
  );

  modport slave (
    input  cfg_data,
    input  cfg_valid,
    output cfg_ready
  );
endinterface

// File: rtl/sos_coef_loader.sv
// Double-buffered coefficient loader for one second-order IIR section.
// Six words (b0, b1, b2, a0, a1, a2) are collected into a shadow buffer.
// The active set is then swapped in one edge on a sample-boundary strobe,
// so the filter never sees a mix of old and new coefficients.
//
// Ports:
//   CLK        rising-edge clock
//   nReset     synchronous active-low reset (works even with CE low)
//   CE         clock enable; when low nothing changes and cfg_ready is 0
//   start      begin a new load (aborts a load already in progress)
//   cfg        coefficient stream (slave side of sos_coef_loader_if)
//   commit_en  sample-boundary strobe that permits the swap
//   coef_b     active b set, b0 in the lowest W bits
//   coef_a     active a set, a0 in the lowest W bits
//   busy       loading or waiting for commit
//   done       one-cycle pulse after a commit
//   err        one-cycle pulse after a load was aborted by start
//   state_dbg  current FSM state
module sos_coef_loader #(
  parameter int TAPSIZE = 3,
  parameter int WI      = 5,
  parameter int WF      = 11,
  localparam int W      = WI + WF
) (
  input  logic                 CLK,
  input  logic                 nReset,
  input  logic                 CE,
  input  logic                 start,
  sos_coef_loader_if.slave     cfg,
  input  logic                 commit_en,
  output logic [3*W-1:0]       coef_b,
  output logic [3*W-1:0]       coef_a,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [1:0]           state_dbg
);

  localparam int          NWORDS = 2 * TAPSIZE;
  localparam logic [2:0]  LAST   = 3'(NWORDS - 1);
  localparam logic [W-1:0] ONE   = W'(1) << WF;
  localparam logic [3*W-1:0] IDENT = {{(2*W){1'b0}}, ONE};

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    LOAD        = 2'd1,
    WAIT_COMMIT = 2'd2
  } state_t;

  state_t       state, state_n;
  logic [2:0]   cnt, cnt_n;
  logic         ready, xfer, commit, abort;
  logic [W-1:0] shadow [NWORDS];

  // State register
  always_ff @(posedge CLK) begin
    if (!nReset) begin
      state <= IDLE;
      cnt   <= '0;
    end else if (CE) begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // Next state and per-cycle strobes. start outranks a coincident
  // transfer or commit_en. cfg_ready stays high during an aborting cycle,
  // but that word is dropped.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    ready   = 1'b0;
    xfer    = 1'b0;
    commit  = 1'b0;
    abort   = 1'b0;
    if (CE) begin
      unique case (state)
        IDLE: begin
          if (start) begin
            state_n = LOAD;
            cnt_n   = '0;
          end
        end
        LOAD: begin
          ready = 1'b1;
          if (start) begin
            abort = 1'b1;
            cnt_n = '0;
          end else if (cfg.cfg_valid) begin
            xfer = 1'b1;
            if (cnt == LAST) begin
              state_n = WAIT_COMMIT;
              cnt_n   = '0;
            end else begin
              cnt_n = cnt + 3'd1;
            end
          end
        end
        WAIT_COMMIT: begin
          if (start) begin
            abort   = 1'b1;
            state_n = LOAD;
            cnt_n   = '0;
          end else if (commit_en) begin
            commit  = 1'b1;
            state_n = IDLE;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // Shadow buffer, active set and status pulses
  always_ff @(posedge CLK) begin
    if (!nReset) begin
      for (int i = 0; i < NWORDS; i++) shadow[i] <= '0;
      coef_b <= IDENT;
      coef_a <= IDENT;
      done   <= 1'b0;
      err    <= 1'b0;
    end else if (CE) begin
      done <= commit;
      err  <= abort;
      if (xfer) shadow[cnt] <= cfg.cfg_data;
      if (commit) begin
        coef_b <= {shadow[2], shadow[1], shadow[0]};
        coef_a <= {shadow[5], shadow[4], shadow[3]};
      end
    end
  end

  assign cfg.cfg_ready = ready;
  assign busy          = (state != IDLE);
  assign state_dbg     = state;

endmodule

// File: tb/tb_sos_coef_loader.sv
module tb_sos_coef_loader;
  localparam int W = 16;
  localparam logic [W-1:0]   ONE = 16'h0800;
  localparam logic [3*W-1:0] ID  = 48'h0000_0000_0800;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             nReset, CE, start, commit_en;
  logic [3*W-1:0]   coef_b, coef_a;
  logic             busy, done, err;
  logic [1:0]       state_dbg;

  sos_coef_loader_if #(.W(W)) cfg ();

  sos_coef_loader #(.TAPSIZE(3), .WI(5), .WF(11)) dut (
    .CLK       (clk),
    .nReset    (nReset),
    .CE        (CE),
    .start     (start),
    .cfg       (cfg),
    .commit_en (commit_en),
    .coef_b    (coef_b),
    .coef_a    (coef_a),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .state_dbg (state_dbg)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [3*W-1:0] act, input logic [3*W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Words accepted for the pending set live in exp_q; the active set is
  // replaced from it when a commit is allowed.
  logic [W-1:0] exp_q[$];
  logic [W-1:0] m_b[3], m_a[3];
  bit m_coll, m_wait, m_done, m_err;

  function automatic logic [3*W-1:0] pack3(input logic [W-1:0] v[3]);
    return {v[2], v[1], v[0]};
  endfunction

  task automatic model_step(input logic r, ce_i, st, v, input logic [W-1:0] d, input logic cm);
    if (!r) begin
      m_coll = 0; m_wait = 0; m_done = 0; m_err = 0;
      exp_q.delete();
      m_b = '{ONE, 16'h0, 16'h0};
      m_a = '{ONE, 16'h0, 16'h0};
    end else if (ce_i) begin
      m_done = 0;
      m_err  = 0;
      if (st) begin
        if (m_coll || m_wait) m_err = 1;
        m_coll = 1;
        m_wait = 0;
        exp_q.delete();
      end else if (m_coll && v) begin
        exp_q.push_back(d);
        if (exp_q.size() == 6) begin
          m_coll = 0;
          m_wait = 1;
        end
      end else if (m_wait && cm) begin
        for (int i = 0; i < 3; i++) begin
          m_b[i] = exp_q[i];
          m_a[i] = exp_q[i+3];
        end
        m_done = 1;
        m_wait = 0;
      end
    end
  endtask

  // ---------------- driver ----------------
  // Called at a falling edge: drive, check cfg_ready, clock, check outputs.
  task automatic cycle(input logic r, ce_i, st, v, input logic [W-1:0] d,
                       input logic cm, input bit chk_model);
    nReset        = r;
    CE            = ce_i;
    start         = st;
    cfg.cfg_valid = v;
    cfg.cfg_data  = d;
    commit_en     = cm;
    #1;
    if (chk_model) chk("cfg_ready", 48'(cfg.cfg_ready), 48'(ce_i && m_coll));
    @(posedge clk);
    model_step(r, ce_i, st, v, d, cm);
    @(negedge clk);
    if (chk_model) begin
      chk("busy",   48'(busy), 48'(m_coll || m_wait));
      chk("done",   48'(done), 48'(m_done));
      chk("err",    48'(err),  48'(m_err));
      chk("coef_b", coef_b, pack3(m_b));
      chk("coef_a", coef_a, pack3(m_a));
      chk("done_err_excl", 48'(done & err), 48'(0));
    end
  endtask

  task automatic send(input logic [W-1:0] d);
    cycle(1, 1, 0, 1, d, 0, 1);
  endtask

  task automatic idle(input int n, input logic cm);
    for (int i = 0; i < n; i++) cycle(1, 1, 0, 0, 16'h0, cm, 1);
  endtask

  task automatic do_start();
    cycle(1, 1, 1, 0, 16'h0, 0, 1);
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic r, ce, st, v;
    logic [W-1:0] d;
    logic cm;
    logic e_ready, e_busy, e_done, e_err;
    logic [3*W-1:0] e_b, e_a;
  } vec_t;

  localparam logic [3*W-1:0] NB = 48'h0400_0800_0400;
  localparam logic [3*W-1:0] NA = 48'h0200_F000_0800;

  vec_t vt[13];

  initial begin
    vt[0]  = '{0,1,0,1,16'h1234,0, 0,0,0,0, ID, ID};
    vt[1]  = '{0,0,0,0,16'h0000,0, 0,0,0,0, ID, ID};
    vt[2]  = '{1,1,0,1,16'h1234,0, 0,0,0,0, ID, ID};
    vt[3]  = '{1,1,1,0,16'h0000,0, 0,1,0,0, ID, ID};
    vt[4]  = '{1,1,0,1,16'h0400,0, 1,1,0,0, ID, ID};
    vt[5]  = '{1,1,0,1,16'h0800,0, 1,1,0,0, ID, ID};
    vt[6]  = '{1,1,0,1,16'h0400,0, 1,1,0,0, ID, ID};
    vt[7]  = '{1,1,0,1,16'h0800,0, 1,1,0,0, ID, ID};
    vt[8]  = '{1,1,0,1,16'hF000,0, 1,1,0,0, ID, ID};
    vt[9]  = '{1,1,0,1,16'h0200,0, 1,1,0,0, ID, ID};
    vt[10] = '{1,1,0,0,16'h0000,1, 0,0,1,0, NB, NA};
    vt[11] = '{1,1,0,0,16'h0000,1, 0,0,0,0, NB, NA};
    vt[12] = '{1,1,0,1,16'h5555,0, 0,0,0,0, NB, NA};

    nReset = 0; CE = 0; start = 0; commit_en = 0;
    cfg.cfg_valid = 0; cfg.cfg_data = '0;
    @(negedge clk);
    cycle(0, 1, 0, 0, 16'h0, 0, 0);

    for (int i = 0; i < 13; i++) begin
      nReset = vt[i].r; CE = vt[i].ce; start = vt[i].st;
      cfg.cfg_valid = vt[i].v; cfg.cfg_data = vt[i].d; commit_en = vt[i].cm;
      #1;
      chk($sformatf("tbl%0d_ready", i), 48'(cfg.cfg_ready), 48'(vt[i].e_ready));
      @(posedge clk);
      model_step(vt[i].r, vt[i].ce, vt[i].st, vt[i].v, vt[i].d, vt[i].cm);
      @(negedge clk);
      chk($sformatf("tbl%0d_busy", i), 48'(busy), 48'(vt[i].e_busy));
      chk($sformatf("tbl%0d_done", i), 48'(done), 48'(vt[i].e_done));
      chk($sformatf("tbl%0d_err", i),  48'(err),  48'(vt[i].e_err));
      chk($sformatf("tbl%0d_b", i), coef_b, vt[i].e_b);
      chk($sformatf("tbl%0d_a", i), coef_a, vt[i].e_a);
    end

    // Valid toggling plus CE low for 3 cycles mid-load
    do_start();
    send(16'h1111);
    cycle(1, 1, 0, 0, 16'hDEAD, 0, 1);
    send(16'h2222);
    for (int i = 0; i < 3; i++) cycle(1, 0, 0, 1, 16'hBEEF, 1, 1);
    send(16'h3333);
    cycle(1, 1, 0, 0, 16'hDEAD, 0, 1);
    send(16'h8444);
    send(16'h5555);
    cycle(1, 1, 0, 0, 16'hDEAD, 0, 1);
    send(16'hF666);
    cycle(1, 1, 0, 1, 16'h7777, 0, 1);   // extra word must not be taken
    idle(1, 1);
    chk("ce_load_b", coef_b, 48'h3333_2222_1111);
    chk("ce_load_a", coef_a, 48'hF666_5555_8444);

    // Hold in WAIT_COMMIT for 20 cycles, then commit
    do_start();
    for (int i = 0; i < 6; i++) send(16'(16'hA000 + i));
    idle(20, 0);
    chk("hold_busy", 48'(busy), 48'(1));
    idle(1, 1);
    chk("hold_b", coef_b, 48'hA002_A001_A000);
    chk("hold_a", coef_a, 48'hA005_A004_A003);

    // Abort after 3 words, then a clean load
    do_start();
    for (int i = 0; i < 3; i++) send(16'(16'h0100 + i));
    do_start();
    chk("abort_err", 48'(err), 48'(1));
    chk("abort_b_kept", coef_b, 48'hA002_A001_A000);
    for (int i = 0; i < 6; i++) send(16'(16'h0C00 + i));
    cycle(1, 1, 1, 0, 16'h0, 1, 1);      // start beats commit_en
    for (int i = 0; i < 6; i++) send(16'(16'h0D00 + i));
    idle(2, 1);
    chk("abort_reload_a", coef_a, 48'h0D05_0D04_0D03);

    // Reset mid-load after 4 words
    do_start();
    for (int i = 0; i < 4; i++) send(16'(16'h0E00 + i));
    cycle(0, 1, 0, 1, 16'h0E04, 1, 1);
    chk("rst_b", coef_b, ID);
    chk("rst_a", coef_a, ID);
    idle(3, 1);

    // Randomized traffic against the model
    for (int i = 0; i < 2000; i++) begin
      logic r, ce_i, st, v, cm;
      logic [W-1:0] d;
      r    = ($urandom_range(0, 199) != 0);
      ce_i = ($urandom_range(0, 9) != 0);
      st   = ($urandom_range(0, 39) == 0);
      v    = $urandom_range(0, 1) == 1;
      cm   = ($urandom_range(0, 2) == 0);
      d    = 16'($urandom);
      cycle(r, ce_i, st, v, d, cm, 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
